// File: rtl/mem_port_arbiter_if.sv
// Requester-side bundle for the memory port arbiter: the instruction-fetch
// port (read-only) and the data port (loads and stores).
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
) ();
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_wdone;

    // Core side: issues requests, receives grants and completions.
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_wdone
    );

    // Arbiter side.
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_wdone
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// One transaction in flight; data has fixed priority, but a fetch is forced
// after MAX_WAIT consecutive data grants taken while fetch was pending.
// Every output, including the memory pins, comes straight from a register.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 7,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    mem_port_arbiter_if.slave bus,
    output logic              CS,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Mem_Bus,
    output logic              busy
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRd   = 2'd1;
    localparam logic [1:0] StWr   = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    localparam int unsigned FW_W    = $clog2(MAX_WAIT + 1);
    localparam logic [FW_W-1:0] MaxWait = FW_W'(MAX_WAIT);
    localparam logic [2:0]  LatInit = 3'(RD_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              port_data_q, port_data_d;  // 1: data port owns the transaction
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        lat_q, lat_d;
    logic [FW_W-1:0]   fw_q, fw_d;

    logic              if_gnt_q, if_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic              d_wdone_q, d_wdone_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              cs_q, cs_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              drive_q, drive_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic              fetch_win;
    logic              is_store;
    logic [ADDR_W-1:0] sel_addr;

    // Winner selection: data first unless fetch has waited MAX_WAIT data grants.
    always_comb begin
        accept    = (state_q == StIdle) && (bus.if_req || bus.d_req);
        fetch_win = bus.if_req && (!bus.d_req || (fw_q >= MaxWait));
        is_store  = !fetch_win && bus.d_we;
        sel_addr  = fetch_win ? bus.if_addr : bus.d_addr;
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        port_data_d = port_data_q;
        wdata_d     = wdata_q;
        lat_d       = lat_q;
        fw_d        = fw_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        d_wdone_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        cs_d        = 1'b0;
        we_d        = 1'b0;
        mem_addr_d  = '0;
        drive_d     = 1'b0;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    addr_d      = sel_addr;
                    port_data_d = !fetch_win;
                    wdata_d     = bus.d_wdata;
                    if_gnt_d    = fetch_win;
                    d_gnt_d     = !fetch_win;
                    cs_d        = 1'b1;
                    mem_addr_d  = sel_addr;
                    if (is_store) begin
                        state_d = StWr;
                        we_d    = 1'b1;
                        drive_d = 1'b1;
                    end else begin
                        state_d = StRd;
                        lat_d   = LatInit;
                    end
                end
            end
            StRd: begin
                if (lat_q == 3'd0) begin
                    // Last CS cycle: capture the memory's read data now.
                    state_d = StDone;
                    if (port_data_q) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = Mem_Bus;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = Mem_Bus;
                    end
                end else begin
                    lat_d      = lat_q - 3'd1;
                    cs_d       = 1'b1;
                    mem_addr_d = addr_q;
                end
            end
            StWr: begin
                state_d   = StDone;
                d_wdone_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Starvation counter: only grows while fetch is actually waiting.
        if (!bus.if_req) begin
            fw_d = '0;
        end else if (accept) begin
            if (fetch_win) begin
                fw_d = '0;
            end else if (fw_q < MaxWait) begin
                fw_d = fw_q + 1'b1;
            end
        end

        busy_d = (state_d != StIdle);
    end

    // State and output registers; reset abandons any transaction in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            port_data_q <= 1'b0;
            wdata_q     <= '0;
            lat_q       <= '0;
            fw_q        <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            d_wdone_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            drive_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            port_data_q <= port_data_d;
            wdata_q     <= wdata_d;
            lat_q       <= lat_d;
            fw_q        <= fw_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            d_wdone_q   <= d_wdone_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            drive_q     <= drive_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.if_gnt    = if_gnt_q;
    assign bus.d_gnt     = d_gnt_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_wdone   = d_wdone_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign CS            = cs_q;
    assign WE            = we_q;
    assign ADDR          = mem_addr_q;
    assign busy          = busy_q;

    // Bus is driven only in the write cycle; memory owns it otherwise.
    assign Mem_Bus = drive_q ? wdata_q : {DATA_W{1'bz}};
endmodule
